// File: rtl/tipi_pkg.sv
// rtl/tipi_pkg.sv - shared encodings and FSM states; TIPI_NIB_CHECK_EN adds check states
package tipi_pkg;

  typedef logic [0:3] nib_t;
  typedef logic [0:7] byte_t;
  typedef logic [0:1] reg_sel_t;

  localparam reg_sel_t REG_TD = 2'b00;
  localparam reg_sel_t REG_TC = 2'b01;
  localparam reg_sel_t REG_RD = 2'b10;
  localparam reg_sel_t REG_RC = 2'b11;

  localparam int CMD_SEL_MSB   = 0;
  localparam int CMD_SEL_LSB   = 1;
  localparam int CMD_WR_BIT    = 2;
  localparam int CMD_START_BIT = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TURN,
    ST_RHI,
    ST_RLO,
    ST_WHI,
    ST_WLO,
    ST_COMMIT,
    ST_DRAIN
`ifdef TIPI_NIB_CHECK_EN
    , ST_RCHK,
    ST_WCHK
`endif
  } state_t;

  function automatic nib_t check_nib(input nib_t hi, input nib_t lo, input nib_t cmd);
    return hi ^ lo ^ cmd;
  endfunction

endpackage

// File: rtl/tipi_nib_ctrl_if.sv
// rtl/tipi_nib_ctrl_if.sv - Pi-side 4-bit nibble bus between the Pi and the controller
interface tipi_nib_ctrl_if;
  import tipi_pkg::*;

  logic r_nibrst;
  nib_t r_nib_i;
  nib_t r_nib_o;
  logic r_nib_oe;

  modport master (
    output r_nibrst,
    output r_nib_i,
    input  r_nib_o,
    input  r_nib_oe
  );

  modport slave (
    input  r_nibrst,
    input  r_nib_i,
    output r_nib_o,
    output r_nib_oe
  );

endinterface

// File: rtl/tipi_nib_mux.sv
// rtl/tipi_nib_mux.sv - register-source select and nibble-half select, shared with TI-side readback
module tipi_nib_mux
  import tipi_pkg::*;
(
  input  byte_t    td_q,
  input  byte_t    tc_q,
  input  byte_t    rd_q,
  input  byte_t    rc_q,
  input  reg_sel_t sel,
  output byte_t    sel_byte,
  input  byte_t    snap,
  input  logic     lo_half,
  output nib_t     nib
);

  always_comb begin
    case (sel)
      REG_TD:  sel_byte = td_q;
      REG_TC:  sel_byte = tc_q;
      REG_RD:  sel_byte = rd_q;
      default: sel_byte = rc_q;
    endcase
  end

  assign nib = lo_half ? snap[4:7] : snap[0:3];

endmodule

// File: rtl/tipi_nib_ctrl.sv
// rtl/tipi_nib_ctrl.sv - TIPI register access sequencer over the Pi nibble bus
// TIPI_NIB_CHECK_EN adds a trailing hi^lo^cmd check nibble to every transaction.
module tipi_nib_ctrl
  import tipi_pkg::*;
#(
  parameter int TURN_CYCLES = 1,
  parameter bit ERR_STICKY  = 1'b1
) (
  input  logic          r_clk,
  input  logic          r_rst_n,
  tipi_nib_ctrl_if.slave nib,
  input  byte_t         td_q,
  input  byte_t         tc_q,
  input  byte_t         rd_q,
  input  byte_t         rc_q,
  output byte_t         wr_data,
  output logic          rd_we,
  output logic          rc_we,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

  state_t   state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic     done_nx;
  logic     err_set;
  reg_sel_t sel_in, sel_q;
  byte_t    snap_q;
  byte_t    live_byte;
  nib_t     half_nib;
`ifdef TIPI_NIB_CHECK_EN
  nib_t     cmd_q;
`endif

  assign sel_in = nib.r_nib_i[CMD_SEL_MSB:CMD_SEL_LSB];

  tipi_nib_mux u_mux (
    .td_q     (td_q),
    .tc_q     (tc_q),
    .rd_q     (rd_q),
    .rc_q     (rc_q),
    .sel      (sel_in),
    .sel_byte (live_byte),
    .snap     (snap_q),
    .lo_half  (state == ST_RLO),
    .nib      (half_nib)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    err_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (nib.r_nib_i[CMD_START_BIT]) begin
          if (!nib.r_nib_i[CMD_WR_BIT]) begin
            state_nx = ST_TURN;
            cnt_nx   = TURN_LAST;
          end else if (sel_in == REG_RD || sel_in == REG_RC) begin
            state_nx = ST_WHI;
          end else begin
            // TD/TC are TI-owned; swallow the two data nibbles so the bus stays framed
            state_nx = ST_DRAIN;
            cnt_nx   = 2'd1;
            err_set  = 1'b1;
          end
        end
      end
      ST_TURN: begin
        if (cnt == 2'd0) state_nx = ST_RHI;
        else             cnt_nx   = cnt - 2'd1;
      end
      ST_RHI: state_nx = ST_RLO;
      ST_RLO: begin
`ifdef TIPI_NIB_CHECK_EN
        state_nx = ST_RCHK;
`else
        state_nx = ST_IDLE;
        done_nx  = 1'b1;
`endif
      end
      ST_WHI: state_nx = ST_WLO;
      ST_WLO: begin
`ifdef TIPI_NIB_CHECK_EN
        state_nx = ST_WCHK;
`else
        state_nx = ST_COMMIT;
        done_nx  = 1'b1;
`endif
      end
`ifdef TIPI_NIB_CHECK_EN
      ST_RCHK: begin
        state_nx = ST_IDLE;
        done_nx  = 1'b1;
      end
      ST_WCHK: begin
        done_nx = 1'b1;
        if (nib.r_nib_i == check_nib(wr_data[0:3], wr_data[4:7], cmd_q)) begin
          state_nx = ST_COMMIT;
        end else begin
          state_nx = ST_IDLE;
          err_set  = 1'b1;
        end
      end
`endif
      ST_COMMIT: state_nx = ST_IDLE;
      ST_DRAIN: begin
        if (cnt == 2'd0) state_nx = ST_IDLE;
        else             cnt_nx   = cnt - 2'd1;
      end
      default: state_nx = ST_IDLE;
    endcase
    // abort wins over anything sampled on the same edge, including a new command
    if (nib.r_nibrst) begin
      state_nx = ST_IDLE;
      cnt_nx   = 2'd0;
      done_nx  = 1'b0;
      err_set  = 1'b0;
    end
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 2'd0;
      sel_q   <= REG_TD;
      snap_q  <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef TIPI_NIB_CHECK_EN
      cmd_q   <= '0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
      if (nib.r_nibrst)    err <= 1'b0;
      else if (err_set)    err <= 1'b1;
      else if (!ERR_STICKY) err <= 1'b0;
      if (state == ST_IDLE && state_nx != ST_IDLE) begin
        sel_q <= sel_in;
`ifdef TIPI_NIB_CHECK_EN
        cmd_q <= nib.r_nib_i;
`endif
      end
      if (state == ST_IDLE && state_nx == ST_TURN) snap_q <= live_byte;
      if (state == ST_WHI && state_nx == ST_WLO) wr_data[0:3] <= nib.r_nib_i;
      if (state == ST_WLO && state_nx != ST_IDLE) wr_data[4:7] <= nib.r_nib_i;
    end
  end

  always_comb begin
    nib.r_nib_o = '0;
    case (state)
      ST_RHI, ST_RLO: nib.r_nib_o = half_nib;
`ifdef TIPI_NIB_CHECK_EN
      ST_RCHK: nib.r_nib_o = check_nib(snap_q[0:3], snap_q[4:7], cmd_q);
`endif
      default: nib.r_nib_o = '0;
    endcase
  end

`ifdef TIPI_NIB_CHECK_EN
  assign nib.r_nib_oe = (state == ST_TURN) || (state == ST_RHI) ||
                        (state == ST_RLO)  || (state == ST_RCHK);
`else
  assign nib.r_nib_oe = (state == ST_TURN) || (state == ST_RHI) || (state == ST_RLO);
`endif

  assign rd_we = (state == ST_COMMIT) && (sel_q == REG_RD);
  assign rc_we = (state == ST_COMMIT) && (sel_q == REG_RC);
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_tipi_nib_ctrl.sv
// tb/tb_tipi_nib_ctrl.sv - scoreboard bench for tipi_nib_ctrl (honours TIPI_NIB_CHECK_EN)
`timescale 1ns/1ps
module tb_tipi_nib_ctrl;
  import tipi_pkg::*;

  localparam int TURN = 1;
`ifdef TIPI_NIB_CHECK_EN
  localparam int NCHK = 1;
`else
  localparam int NCHK = 0;
`endif
  localparam int K_READ  = 0;
  localparam int K_WRITE = 1;
  localparam int K_WFAIL = 2;

  typedef struct {
    int         kind;
    int         sel;
    logic [0:7] data;
    logic [0:3] cmd;
  } exp_t;

  logic       r_clk = 1'b0;
  logic       r_rst_n = 1'b0;
  logic [0:7] regv [4];
  logic [0:7] wr_data;
  logic       rd_we, rc_we, busy, done, err;

  tipi_nib_ctrl_if nb ();

  tipi_nib_ctrl #(.TURN_CYCLES(TURN), .ERR_STICKY(1'b1)) dut (
    .r_clk   (r_clk),
    .r_rst_n (r_rst_n),
    .nib     (nb),
    .td_q    (regv[0]),
    .tc_q    (regv[1]),
    .rd_q    (regv[2]),
    .rc_q    (regv[3]),
    .wr_data (wr_data),
    .rd_we   (rd_we),
    .rc_we   (rc_we),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 r_clk = ~r_clk;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  bit   aborting = 1'b0;
  bit   exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: output event with empty scoreboard", name);
  endtask

  // Monitor: pops one expectation per completion event seen on the outputs.
  int         olen = 0;
  logic [0:3] m_hi, m_lo, m_ck;
  logic       prev_oe = 1'b0;
  exp_t       me;

  initial begin
    m_hi = '0; m_lo = '0; m_ck = '0;
    forever begin
      @(negedge r_clk);
      if (nb.r_nib_oe) begin
        olen++;
        if (olen == TURN + 1) m_hi = nb.r_nib_o;
        if (olen == TURN + 2) m_lo = nb.r_nib_o;
        if (olen == TURN + 3) m_ck = nb.r_nib_o;
      end
      if (prev_oe && !nb.r_nib_oe) begin
        if (!aborting) begin
          chk("read_done", done, 1);
          if (sbq.size() == 0) flag("read_unexpected");
          else begin
            me = sbq.pop_front();
            chk("read_kind", me.kind, K_READ);
            chk("read_hi", m_hi, me.data[0:3]);
            chk("read_lo", m_lo, me.data[4:7]);
            chk("oe_window", olen, TURN + 2 + NCHK);
`ifdef TIPI_NIB_CHECK_EN
            chk("read_chk", m_ck, me.data[0:3] ^ me.data[4:7] ^ me.cmd);
`endif
          end
        end
        olen = 0;
      end
      if (rd_we || rc_we) begin
        chk("we_onehot", rd_we & rc_we, 0);
        chk("we_done", done, 1);
        if (sbq.size() == 0) flag("write_unexpected");
        else begin
          me = sbq.pop_front();
          chk("write_kind", me.kind, K_WRITE);
          chk("write_sel", rc_we ? 3 : 2, me.sel);
          chk("wr_data", wr_data, me.data);
        end
      end else if (done && !(prev_oe && !nb.r_nib_oe)) begin
        if (sbq.size() == 0) flag("done_unexpected");
        else begin
          me = sbq.pop_front();
          chk("wfail_kind", me.kind, K_WFAIL);
          chk("wfail_err", err, 1);
        end
      end
      prev_oe = nb.r_nib_oe;
    end
  end

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  function automatic logic [0:3] mk_cmd(input int sel, input bit wr);
    logic [0:3] c;
    c[0:1] = 2'(sel);
    c[2]   = wr;
    c[3]   = 1'b1;
    return c;
  endfunction

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      nb.r_nib_i = 4'($urandom_range(0, 15)) & 4'b1110;
      tick();
    end
    chk("gap_busy", busy, 0);
  endtask

  task automatic do_read(input int sel);
    logic [0:3] c;
    exp_t e;
    c = mk_cmd(sel, 1'b0);
    e = '{K_READ, sel, regv[sel], c};
    sbq.push_back(e);
    nb.r_nib_i = c;
    tick();
    chk("rd_busy", busy, 1);
    for (int r = 0; r < 4; r++) regv[r] = 8'($urandom);
    for (int i = 0; i < TURN + 2 + NCHK; i++) begin
      nb.r_nib_i = 4'($urandom);
      tick();
    end
    chk("rd_idle", busy, 0);
    chk("rd_err", err, exp_err);
  endtask

  task automatic do_write(input int sel, input logic [0:7] data, input logic [0:3] bad);
    logic [0:3] c;
    exp_t e;
    c = mk_cmd(sel, 1'b1);
    nb.r_nib_i = c;
    tick();
    chk("wr_busy", busy, 1);
    if (sel < 2) begin
      exp_err = 1'b1;
      chk("illegal_err", err, 1);
      for (int i = 0; i < 2; i++) begin
        nb.r_nib_i = 4'($urandom);
        tick();
      end
      chk("illegal_idle", busy, 0);
      return;
    end
`ifdef TIPI_NIB_CHECK_EN
    e = '{(bad != 0) ? K_WFAIL : K_WRITE, sel, data, c};
`else
    e = '{K_WRITE, sel, data, c};
`endif
    sbq.push_back(e);
    nb.r_nib_i = data[0:3];
    tick();
    nb.r_nib_i = data[4:7];
    tick();
`ifdef TIPI_NIB_CHECK_EN
    nb.r_nib_i = data[0:3] ^ data[4:7] ^ c ^ bad;
    tick();
    if (bad != 0) begin
      exp_err = 1'b1;
      chk("wchk_idle", busy, 0);
      chk("wchk_err", err, 1);
      return;
    end
`endif
    nb.r_nib_i = 4'h0;
    tick();
    chk("wr_idle", busy, 0);
    chk("wr_err", err, exp_err);
  endtask

  task automatic abort_idle();
    nb.r_nibrst = 1'b1;
    nb.r_nib_i  = mk_cmd($urandom_range(0, 3), 1'b0);
    tick();
    nb.r_nibrst = 1'b0;
    nb.r_nib_i  = 4'h0;
    exp_err = 1'b0;
    chk("abort_cmd_busy", busy, 0);
    chk("abort_err", err, 0);
  endtask

  initial begin
    logic [0:3] badv;
    nb.r_nibrst = 1'b0;
    nb.r_nib_i  = 4'h0;
    for (int r = 0; r < 4; r++) regv[r] = 8'h00;
    repeat (3) tick();
    chk("rst_oe", nb.r_nib_oe, 0);
    chk("rst_nib_o", nb.r_nib_o, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_we", rd_we, 0);
    chk("rst_rc_we", rc_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    r_rst_n = 1'b1;
    tick();

    regv[0] = 8'hA5;
    do_read(0);
    do_write(3, 8'h3C, 4'h0);

    do_write(0, 8'h55, 4'h0);
    do_read(2);
    chk("err_held", err, 1);
    idle_gap(2);
    chk("err_still", err, 1);
    abort_idle();

    nb.r_nib_i = mk_cmd(2, 1'b1);
    tick();
    nb.r_nib_i = 4'h7;
    tick();
    nb.r_nibrst = 1'b1;
    nb.r_nib_i  = 4'h9;
    tick();
    nb.r_nibrst = 1'b0;
    nb.r_nib_i  = 4'h0;
    chk("abort_wr_busy", busy, 0);
    do_write(2, 8'hFF, 4'h0);

`ifdef TIPI_NIB_CHECK_EN
    do_write(2, 8'h12, 4'h0);
    do_write(2, 8'h12, 4'h8);
    abort_idle();
`endif

    nb.r_nib_i = mk_cmd(1, 1'b0);
    tick();
    tick();
    aborting = 1'b1;
    r_rst_n  = 1'b0;
    #1;
    chk("arst_oe", nb.r_nib_oe, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rd_we", rd_we, 0);
    chk("arst_rc_we", rc_we, 0);
    chk("arst_wr_data", wr_data, 0);
    tick();
    r_rst_n = 1'b1;
    nb.r_nib_i = 4'h0;
    exp_err = 1'b0;
    tick();
    aborting = 1'b0;

    for (int n = 0; n < 80; n++) begin
      int k;
      k = $urandom_range(0, 9);
      for (int r = 0; r < 4; r++) regv[r] = 8'($urandom);
      badv = 4'h0;
`ifdef TIPI_NIB_CHECK_EN
      if ($urandom_range(0, 3) == 0) badv = 4'($urandom_range(1, 15));
`endif
      if (k < 4)       do_read($urandom_range(0, 3));
      else if (k < 7)  do_write($urandom_range(2, 3), 8'($urandom), badv);
      else if (k == 7) do_write($urandom_range(0, 1), 8'($urandom), 4'h0);
      else if (k == 8) idle_gap($urandom_range(1, 3));
      else             abort_idle();
    end

    idle_gap(4);
    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
